// File: rtl/itcm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// itcm_ctrl_pkg
// Shared core defines (bus widths, ITCM base address, loader state encodings)
// and the package that turns them into typed declarations for the ITCM
// controller slice.
// No ports.
// ----------------------------------------------------------------------------
`ifndef ITCM_CORE_DEFINES
`define ITCM_CORE_DEFINES
`define ADDR_WIDTH      32
`define DATA_WIDTH      32
`define INSTR_WIDTH     32
`define ITCM_START_ADDR 32'h0000_0000
`define ITCM_ST_IDLE     2'd0
`define ITCM_ST_LOAD_REQ 2'd1
`define ITCM_ST_LOAD_WR  2'd2
`define ITCM_ST_DONE     2'd3
`endif

package itcm_ctrl_pkg;

    localparam int ADDR_W  = `ADDR_WIDTH;
    localparam int DATA_W  = `DATA_WIDTH;
    localparam int INSTR_W = `INSTR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE     = `ITCM_ST_IDLE,
        ST_LOAD_REQ = `ITCM_ST_LOAD_REQ,
        ST_LOAD_WR  = `ITCM_ST_LOAD_WR,
        ST_DONE     = `ITCM_ST_DONE
    } ld_state_t;

endpackage

// File: rtl/itcm_ctrl_if.sv
// ----------------------------------------------------------------------------
// itcm_ctrl_if
// Bundles the three buses around the ITCM controller:
//   fetch side : instr_itcm_access/addr in, read_data/read_data_valid and
//                itcm_auto_load out
//   boot load  : load_req/load_addr out, load_rdata/load_rdata_valid in
//   SRAM macro : sram_cs/we/addr/wdata out, sram_rdata in
// Modport slave is the controller's view, master is the surrounding system.
// ----------------------------------------------------------------------------
interface itcm_ctrl_if
    import itcm_ctrl_pkg::*;
#(
    parameter int AW = 12
);
    logic                instr_itcm_access;
    logic [ADDR_W-1:0]   instr_itcm_addr;
    logic [INSTR_W-1:0]  instr_itcm_read_data;
    logic                instr_itcm_read_data_valid;
    logic                itcm_auto_load;

    logic                load_req;
    logic [ADDR_W-1:0]   load_addr;
    logic [DATA_W-1:0]   load_rdata;
    logic                load_rdata_valid;

    logic                sram_cs;
    logic                sram_we;
    logic [AW-1:0]       sram_addr;
    logic [DATA_W-1:0]   sram_wdata;
    logic [DATA_W-1:0]   sram_rdata;

    modport slave (
        input  instr_itcm_access, instr_itcm_addr,
        output instr_itcm_read_data, instr_itcm_read_data_valid, itcm_auto_load,
        output load_req, load_addr,
        input  load_rdata, load_rdata_valid,
        output sram_cs, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output instr_itcm_access, instr_itcm_addr,
        input  instr_itcm_read_data, instr_itcm_read_data_valid, itcm_auto_load,
        input  load_req, load_addr,
        output load_rdata, load_rdata_valid,
        input  sram_cs, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/itcm_ctrl_auto_loader.sv
// ----------------------------------------------------------------------------
// itcm_auto_loader
// Boot-time copier: after reset it reads ITCM_WORDS words from the AHB boot
// memory starting at LOAD_SRC_BASE and writes them to ITCM SRAM words
// 0..ITCM_WORDS-1, one request/write pair per word.
// Ports:
//   cpu_clk, cpu_rstn          clock, async active-low reset
//   load_req/load_addr         AHB boot read request and byte address
//   load_rdata/_valid          AHB boot read response
//   wr_cs/wr_we/wr_addr/wr_wdata  SRAM write-side signals (zero when idle)
//   auto_load                  high until the copy has finished
//   done                       loader has released the SRAM port
// ----------------------------------------------------------------------------
module itcm_auto_loader
    import itcm_ctrl_pkg::*;
#(
    parameter int          ITCM_WORDS    = 4096,
    parameter bit          AUTO_LOAD     = 1'b1,
    parameter logic [31:0] LOAD_SRC_BASE = 32'h0010_0000,
    localparam int         AW            = $clog2(ITCM_WORDS)
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    output logic              load_req,
    output logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_rdata,
    input  logic              load_rdata_valid,
    output logic              wr_cs,
    output logic              wr_we,
    output logic [AW-1:0]     wr_addr,
    output logic [DATA_W-1:0] wr_wdata,
    output logic              auto_load,
    output logic              done
);

    ld_state_t         state_q, state_d;
    // One bit wider than a word index so the count can reach ITCM_WORDS.
    logic [AW:0]       cnt_q;
    logic [DATA_W-1:0] word_q;
    logic              last_word;

    assign last_word = (cnt_q == (AW+1)'(ITCM_WORDS - 1));
    assign load_addr = LOAD_SRC_BASE + (ADDR_W'(cnt_q) << 2);
    assign done      = (state_q == ST_DONE);
    assign auto_load = ~done;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_LOAD_WR)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Captured boot word is pure data: no reset needed, the write strobe
    // and output zeroing below keep it invisible until it is valid.
    always_ff @(posedge cpu_clk) begin
        if (state_q == ST_LOAD_REQ && load_rdata_valid)
            word_q <= load_rdata;
    end

    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        wr_cs    = 1'b0;
        wr_we    = 1'b0;
        wr_addr  = '0;
        wr_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                state_d = AUTO_LOAD ? ST_LOAD_REQ : ST_DONE;
            end
            ST_LOAD_REQ: begin
                load_req = 1'b1;
                if (load_rdata_valid)
                    state_d = ST_LOAD_WR;
            end
            ST_LOAD_WR: begin
                wr_cs    = 1'b1;
                wr_we    = 1'b1;
                wr_addr  = cnt_q[AW-1:0];
                wr_wdata = word_q;
                state_d  = last_word ? ST_DONE : ST_LOAD_REQ;
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

endmodule

// File: rtl/itcm_ctrl.sv
// ----------------------------------------------------------------------------
// itcm_ctrl
// Instruction-TCM responder. Serves single-cycle-issue, one-cycle-latency
// fetch reads from the ITCM SRAM once the boot auto-load has finished.
// Ports:
//   cpu_clk, cpu_rstn  clock, async active-low reset
//   bus                itcm_ctrl_if.slave: fetch port, boot-load port and
//                      SRAM macro port
// ----------------------------------------------------------------------------
module itcm_ctrl
    import itcm_ctrl_pkg::*;
#(
    parameter int          ITCM_WORDS    = 4096,
    parameter bit          AUTO_LOAD     = 1'b1,
    parameter logic [31:0] LOAD_SRC_BASE = 32'h0010_0000,
    localparam int         AW            = $clog2(ITCM_WORDS)
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    itcm_ctrl_if.slave  bus
);

    logic              ld_cs, ld_we, ld_done, ld_auto_load;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic [AW-1:0]     fetch_idx;
    logic              acc_r;

    itcm_auto_loader #(
        .ITCM_WORDS    (ITCM_WORDS),
        .AUTO_LOAD     (AUTO_LOAD),
        .LOAD_SRC_BASE (LOAD_SRC_BASE)
    ) u_loader (
        .cpu_clk          (cpu_clk),
        .cpu_rstn         (cpu_rstn),
        .load_req         (bus.load_req),
        .load_addr        (bus.load_addr),
        .load_rdata       (bus.load_rdata),
        .load_rdata_valid (bus.load_rdata_valid),
        .wr_cs            (ld_cs),
        .wr_we            (ld_we),
        .wr_addr          (ld_addr),
        .wr_wdata         (ld_wdata),
        .auto_load        (ld_auto_load),
        .done             (ld_done)
    );

    assign bus.itcm_auto_load = ld_auto_load;

    // Word index relative to the ITCM base; upper bits fall away, so
    // out-of-range addresses wrap modulo ITCM_WORDS.
    assign fetch_idx = AW'((bus.instr_itcm_addr - `ITCM_START_ADDR) >> 2);

    // The loader owns the single SRAM port until it reports done.
    always_comb begin
        bus.sram_cs    = 1'b0;
        bus.sram_we    = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        if (!ld_done) begin
            bus.sram_cs    = ld_cs;
            bus.sram_we    = ld_we;
            bus.sram_addr  = ld_addr;
            bus.sram_wdata = ld_wdata;
        end else if (bus.instr_itcm_access) begin
            bus.sram_cs   = 1'b1;
            bus.sram_addr = fetch_idx;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn)
            acc_r <= 1'b0;
        else
            acc_r <= ld_done & bus.instr_itcm_access;
    end

    assign bus.instr_itcm_read_data_valid = acc_r;
    assign bus.instr_itcm_read_data       = acc_r ? INSTR_W'(bus.sram_rdata) : '0;

endmodule

// File: tb/tb_itcm_ctrl.sv
`ifndef ITCM_CORE_DEFINES
`define ITCM_CORE_DEFINES
`define ADDR_WIDTH      32
`define DATA_WIDTH      32
`define INSTR_WIDTH     32
`define ITCM_START_ADDR 32'h0000_0000
`define ITCM_ST_IDLE     2'd0
`define ITCM_ST_LOAD_REQ 2'd1
`define ITCM_ST_LOAD_WR  2'd2
`define ITCM_ST_DONE     2'd3
`endif

module tb_itcm_ctrl;

    localparam int          W    = 4;
    localparam int          AW   = 2;
    localparam logic [31:0] BASE = 32'h0010_0000;

    logic cpu_clk  = 1'b0;
    logic cpu_rstn = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    itcm_ctrl_if #(.AW(AW)) b0 ();
    itcm_ctrl_if #(.AW(AW)) b1 ();

    itcm_ctrl #(.ITCM_WORDS(W), .AUTO_LOAD(1'b1), .LOAD_SRC_BASE(BASE)) u_dut0 (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .bus      (b0)
    );

    itcm_ctrl #(.ITCM_WORDS(W), .AUTO_LOAD(1'b0), .LOAD_SRC_BASE(BASE)) u_dut1 (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .bus      (b1)
    );

    // AHB boot memory model: word i holds 0xA0+i, wait_n wait states per read.
    int wait_n = 0;
    int wc     = 0;
    always @(posedge cpu_clk) begin
        if (!b0.load_req || wc == wait_n) wc <= 0;
        else                              wc <= wc + 1;
    end
    always_comb begin
        b0.load_rdata_valid = b0.load_req && (wc == wait_n);
        b0.load_rdata       = b0.load_rdata_valid ? (32'hA0 + ((b0.load_addr - BASE) >> 2))
                                                  : 32'hDEAD_BEEF;
    end
    assign b1.load_rdata       = '0;
    assign b1.load_rdata_valid = 1'b0;

    // SRAM models.
    logic [31:0] mem0 [W];
    always @(posedge cpu_clk) begin
        if (b0.sram_cs) begin
            if (b0.sram_we) mem0[b0.sram_addr] <= b0.sram_wdata;
            else            b0.sram_rdata      <= mem0[b0.sram_addr];
        end
    end
    always @(posedge cpu_clk) begin
        if (b1.sram_cs && !b1.sram_we) b1.sram_rdata <= 32'h5000 + 32'(b1.sram_addr);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    typedef struct {
        logic        acc;
        logic [31:0] addr;
        logic        exp_cs;
        logic        exp_vld;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tv [9];

    initial begin
        int req_cycles;
        int wr_cycles;

        tv[0] = '{1'b1, `ITCM_START_ADDR + 32'h8,  1'b1, 1'b0, 32'h0};
        tv[1] = '{1'b0, `ITCM_START_ADDR,          1'b0, 1'b1, 32'hA2};
        tv[2] = '{1'b1, `ITCM_START_ADDR + 32'h0,  1'b1, 1'b0, 32'h0};
        tv[3] = '{1'b1, `ITCM_START_ADDR + 32'h4,  1'b1, 1'b1, 32'hA0};
        tv[4] = '{1'b1, `ITCM_START_ADDR + 32'hC,  1'b1, 1'b1, 32'hA1};
        tv[5] = '{1'b0, `ITCM_START_ADDR,          1'b0, 1'b1, 32'hA3};
        tv[6] = '{1'b0, `ITCM_START_ADDR,          1'b0, 1'b0, 32'h0};
        tv[7] = '{1'b1, `ITCM_START_ADDR + 32'h14, 1'b1, 1'b0, 32'h0};
        tv[8] = '{1'b0, `ITCM_START_ADDR,          1'b0, 1'b1, 32'hA1};

        b0.instr_itcm_access = 1'b0;
        b0.instr_itcm_addr   = '0;
        b1.instr_itcm_access = 1'b0;
        b1.instr_itcm_addr   = '0;

        // Reset values.
        step();
        step();
        chk("rst_auto_load", 32'(b0.itcm_auto_load), 32'd1);
        chk("rst_load_req",  32'(b0.load_req), 32'd0);
        chk("rst_load_addr", b0.load_addr, BASE);
        chk("rst_sram_cs",   32'(b0.sram_cs), 32'd0);
        chk("rst_sram_we",   32'(b0.sram_we), 32'd0);
        chk("rst_sram_addr", 32'(b0.sram_addr), 32'd0);
        chk("rst_sram_wdata", b0.sram_wdata, 32'd0);
        chk("rst_valid",     32'(b0.instr_itcm_read_data_valid), 32'd0);
        chk("rst_data",      b0.instr_itcm_read_data, 32'd0);
        chk("rst1_auto_load", 32'(b1.itcm_auto_load), 32'd1);

        // Zero-wait auto-load of 4 words; AUTO_LOAD=0 instance checked alongside.
        cpu_rstn = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 1) begin
                b1.instr_itcm_access = 1'b1;
                b1.instr_itcm_addr   = `ITCM_START_ADDR + 32'hC;
            end else begin
                b1.instr_itcm_access = 1'b0;
            end
            #1;
            chk($sformatf("ld_auto_load_c%0d", c), 32'(b0.itcm_auto_load), 32'd1);
            chk($sformatf("ld_req_c%0d", c), 32'(b0.load_req), 32'((c % 2 == 1)));
            if (c % 2 == 1)
                chk($sformatf("ld_addr_c%0d", c), b0.load_addr, BASE + 32'(4 * ((c - 1) / 2)));
            chk($sformatf("ld_cs_c%0d", c), 32'(b0.sram_cs), 32'((c % 2 == 0) && c >= 2));
            if (c % 2 == 0 && c >= 2) begin
                chk($sformatf("ld_we_c%0d", c), 32'(b0.sram_we), 32'd1);
                chk($sformatf("ld_waddr_c%0d", c), 32'(b0.sram_addr), 32'((c - 2) / 2));
                chk($sformatf("ld_wdata_c%0d", c), b0.sram_wdata, 32'hA0 + 32'((c - 2) / 2));
            end
            chk($sformatf("ld_valid_c%0d", c), 32'(b0.instr_itcm_read_data_valid), 32'd0);
            chk($sformatf("n_req_c%0d", c), 32'(b1.load_req), 32'd0);
            if (c == 0) chk("n_auto_load_c0", 32'(b1.itcm_auto_load), 32'd1);
            if (c == 1) chk("n_auto_load_c1", 32'(b1.itcm_auto_load), 32'd0);
            if (c == 2) begin
                chk("n_valid_c2", 32'(b1.instr_itcm_read_data_valid), 32'd1);
                chk("n_data_c2", b1.instr_itcm_read_data, 32'h5003);
            end
            if (c == 3) chk("n_valid_c3", 32'(b1.instr_itcm_read_data_valid), 32'd0);
            step();
        end
        chk("ld_auto_load_c9", 32'(b0.itcm_auto_load), 32'd0);

        // Fetch vectors, first one presented in the first DONE cycle.
        for (int i = 0; i < 9; i++) begin
            b0.instr_itcm_access = tv[i].acc;
            b0.instr_itcm_addr   = tv[i].addr;
            #1;
            chk($sformatf("f%0d_cs", i), 32'(b0.sram_cs), 32'(tv[i].exp_cs));
            chk($sformatf("f%0d_we", i), 32'(b0.sram_we), 32'd0);
            chk($sformatf("f%0d_valid", i), 32'(b0.instr_itcm_read_data_valid), 32'(tv[i].exp_vld));
            chk($sformatf("f%0d_data", i), b0.instr_itcm_read_data, tv[i].exp_data);
            step();
        end

        // Access held during a load with 3 AHB wait states per word.
        cpu_rstn = 1'b0;
        #1;
        step();
        wait_n = 3;
        b0.instr_itcm_access = 1'b1;
        b0.instr_itcm_addr   = `ITCM_START_ADDR + 32'h4;
        cpu_rstn   = 1'b1;
        req_cycles = 0;
        wr_cycles  = 0;
        for (int c = 0; c < 21; c++) begin
            #1;
            if (b0.load_req) req_cycles++;
            if (b0.sram_cs && b0.sram_we) wr_cycles++;
            if (b0.itcm_auto_load !== 1'b1 || b0.instr_itcm_read_data_valid !== 1'b0 ||
                (b0.sram_cs && !b0.sram_we)) begin
                chk($sformatf("ws_c%0d_auto_vld_rd", c),
                    {29'd0, b0.itcm_auto_load, b0.instr_itcm_read_data_valid,
                     b0.sram_cs & ~b0.sram_we}, 32'h4);
            end
            step();
        end
        chk("ws_req_cycles", 32'(req_cycles), 32'd16);
        chk("ws_wr_cycles", 32'(wr_cycles), 32'd4);
        chk("ws_auto_load_c21", 32'(b0.itcm_auto_load), 32'd0);
        chk("ws_cs_c21", 32'(b0.sram_cs), 32'd1);
        step();
        chk("ws_valid_c22", 32'(b0.instr_itcm_read_data_valid), 32'd1);
        chk("ws_data_c22", b0.instr_itcm_read_data, 32'hA1);

        // Reset with a read pending: valid and data drop immediately.
        cpu_rstn = 1'b0;
        #1;
        chk("pend_rst_valid", 32'(b0.instr_itcm_read_data_valid), 32'd0);
        chk("pend_rst_data", b0.instr_itcm_read_data, 32'd0);
        b0.instr_itcm_access = 1'b0;
        wait_n = 0;
        step();

        // Reset while cnt=2 aborts the load; it restarts from word 0.
        cpu_rstn = 1'b1;
        for (int c = 0; c < 5; c++) step();
        chk("mid_req_c5", 32'(b0.load_req), 32'd1);
        chk("mid_addr_c5", b0.load_addr, BASE + 32'h8);
        cpu_rstn = 1'b0;
        #1;
        chk("mid_rst_req", 32'(b0.load_req), 32'd0);
        chk("mid_rst_addr", b0.load_addr, BASE);
        chk("mid_rst_auto_load", 32'(b0.itcm_auto_load), 32'd1);
        chk("mid_rst_cs", 32'(b0.sram_cs), 32'd0);
        chk("mid_rst_sram_addr", 32'(b0.sram_addr), 32'd0);
        chk("mid_rst_wdata", b0.sram_wdata, 32'd0);
        step();
        cpu_rstn = 1'b1;
        #1;
        chk("re_req_c0", 32'(b0.load_req), 32'd0);
        step();
        chk("re_req_c1", 32'(b0.load_req), 32'd1);
        chk("re_addr_c1", b0.load_addr, BASE);
        step();
        chk("re_wr_c2", 32'(b0.sram_cs & b0.sram_we), 32'd1);
        chk("re_waddr_c2", 32'(b0.sram_addr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
